// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern codes, colour constants, default 640x480@60 timing.
// Also holds the clog2 and colour-bar helpers used by the timing and pattern logic.
package vga_pkg;

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  localparam rgb_t C_WHITE   = 12'hFFF;
  localparam rgb_t C_YELLOW  = 12'hFF0;
  localparam rgb_t C_CYAN    = 12'h0FF;
  localparam rgb_t C_GREEN   = 12'h0F0;
  localparam rgb_t C_MAGENTA = 12'hF0F;
  localparam rgb_t C_RED     = 12'hF00;
  localparam rgb_t C_BLUE    = 12'h00F;
  localparam rgb_t C_BLACK   = 12'h000;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_GRID     = 32;

  // Never returns less than 1 so that a value of 1 still yields a usable vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour decode for one pixel; zero latency, no flow control.
// The parent registers the result together with the sync and position outputs.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int GRID     = DEF_GRID,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  pat_e            pat,
  input  rgb_t            color,
  input  logic [HW-1:0]   x,
  input  logic [VW-1:0]   y,
  input  logic            de,
  output rgb_t            rgb
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int GB    = clog2(GRID);

  rgb_t bar_rgb;
  logic on_grid;
  logic on_check;

  always_comb begin
    bar_rgb  = bar_color(3'(x / HW'(BAR_W)));
    on_grid  = ((x & HW'(GRID - 1)) == '0) || ((y & VW'(GRID - 1)) == '0);
    // Bit 0 of the cell index in each axis decides the checker square.
    on_check = (|((x >> GB) & HW'(1))) ^ (|((y >> GB) & VW'(1)));

    rgb = C_BLACK;
    if (de) begin
      case (pat)
        PAT_BARS:  rgb = bar_rgb;
        PAT_GRID:  rgb = on_grid ? C_WHITE : C_BLACK;
        PAT_SOLID: rgb = color;
        PAT_CHECK: rgb = on_check ? C_WHITE : C_BLACK;
        default:   rgb = C_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with frame-synchronous test pattern; outputs lag the
// pixel counters by one pixel. Free-running, no backpressure: pix_en strobes every CLK_DIV cycles.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int GRID     = DEF_GRID,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = clog2(H_TOTAL),
  localparam int VW      = clog2(V_TOTAL)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [1:0]    pat_sel,
  input  logic [11:0]   pat_color,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          frame_start,
  output logic [11:0]   rgb
);

  localparam int DW       = clog2(CLK_DIV);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          frame_top;
  logic          hs_act;
  logic          vs_act;
  logic          act_region;
  pat_e          act_pat;
  pat_e          pat_now;
  rgb_t          act_color;
  rgb_t          color_now;
  rgb_t          pat_rgb;

  always_comb begin
    div_nxt    = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
    h_last     = (int'(h_cnt) == H_TOTAL - 1);
    v_last     = (int'(v_cnt) == V_TOTAL - 1);
    frame_top  = (h_cnt == '0) && (v_cnt == '0);
    hs_act     = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    vs_act     = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    act_region = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    // The first pixel of a frame already uses the freshly sampled selection,
    // so a whole frame is always drawn with one pattern.
    pat_now    = frame_top ? pat_e'(pat_sel) : act_pat;
    color_now  = frame_top ? pat_color : act_color;
  end

  // pix_en is registered from the next divider value, so it is high exactly
  // while div_cnt sits at CLK_DIV-1 and stays low during reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_en  <= (div_nxt == DW'(CLK_DIV - 1));
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .GRID     (GRID),
    .HW       (HW),
    .VW       (VW)
  ) u_pattern (
    .pat   (pat_now),
    .color (color_now),
    .x     (h_cnt),
    .y     (v_cnt),
    .de    (act_region),
    .rgb   (pat_rgb)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      rgb         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      act_pat     <= PAT_BARS;
      act_color   <= '0;
    end else begin
      frame_start <= pix_en && frame_top;
      if (pix_en) begin
        hsync  <= hs_act ? H_POL : ~H_POL;
        vsync  <= vs_act ? V_POL : ~V_POL;
        de     <= act_region;
        rgb    <= pat_rgb;
        hcount <= h_cnt;
        vcount <= v_cnt;
        if (frame_top) begin
          act_pat   <= pat_now;
          act_color <= color_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Self-checking bench for vga_timing_pattern_gen on a 24x12 pixel frame with CLK_DIV=2.
// A per-cycle reference model runs alongside table vectors and hand-written sequences.
module tb_vga_timing_pattern_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
  localparam int CD = 2, GR = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME_CYC = HT * VT * CD;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [11:0] pat_color = 12'h000;
  logic        pix_en, hsync, vsync, de, frame_start;
  logic [4:0]  hcount;
  logic [3:0]  vcount;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;

  vga_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .H_POL (1'b0), .V_POL (1'b0), .CLK_DIV (CD), .GRID (GR)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .pat_sel     (pat_sel),
    .pat_color   (pat_color),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .rgb         (rgb)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [11:0] ref_rgb(input int p, input logic [11:0] c, input int x, input int y);
    if (x >= HA || y >= VA) return 12'h000;
    case (p)
      0: case (x / (HA / 8))
           0: return 12'hFFF;
           1: return 12'hFF0;
           2: return 12'h0FF;
           3: return 12'h0F0;
           4: return 12'hF0F;
           5: return 12'hF00;
           6: return 12'h00F;
           default: return 12'h000;
         endcase
      1: return (x % GR == 0 || y % GR == 0) ? 12'hFFF : 12'h000;
      2: return c;
      default: return ((((x / GR) ^ (y / GR)) % 2) == 1) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  function automatic logic ref_hsync(input int x);
    return !(x >= HA + HFP && x < HA + HFP + HS);
  endfunction

  function automatic logic ref_vsync(input int y);
    return !(y >= VA + VFP && y < VA + VFP + VS);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference model: pixel n of the output stream is shown after the (n+1)-th pix_en
  // since reset release; the pattern is whatever was selected when pixel (0,0) went out.
  int          m_edges = 0, m_x = 0, m_y = 0, m_pat = 0, m_n = 0;
  logic [11:0] m_color = 12'h000;
  logic [25:0] m_exp, m_act;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_edges = 0;
      m_pat   = 0;
      m_color = 12'h000;
    end else begin
      m_edges++;
      if (m_edges >= 2 && m_edges % 2 == 0) begin
        m_n = m_edges / 2 - 1;
        m_x = m_n % HT;
        m_y = (m_n / HT) % VT;
        if (m_x == 0 && m_y == 0) begin
          m_pat   = int'(pat_sel);
          m_color = pat_color;
        end
      end
    end
    #1;
    if (m_edges < 2)
      m_exp = {m_edges == 1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 12'h000};
    else
      m_exp = {m_edges % 2 == 1, ref_hsync(m_x), ref_vsync(m_y), (m_x < HA && m_y < VA),
               (m_edges % 2 == 0 && m_x == 0 && m_y == 0), 5'(m_x), 4'(m_y),
               ref_rgb(m_pat, m_color, m_x, m_y)};
    m_act = {pix_en, hsync, vsync, de, frame_start, hcount, vcount, rgb};
    chk($sformatf("cycle_model_e%0d", m_edges), 32'(m_act), 32'(m_exp));
  end

  task automatic wait_fs(input string nm);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < 2 * FRAME_CYC);
    chk({nm, "_fs_seen"}, 32'(frame_start), 32'd1);
  endtask

  task automatic wait_pix(input int x, input int y, input string nm);
    int k;
    k = 0;
    while (!(int'(hcount) == x && int'(vcount) == y) && k < 2 * FRAME_CYC) begin
      step();
      k++;
    end
    chk({nm, "_pix_found"}, 32'(int'(hcount) == x && int'(vcount) == y), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] color;
    int          x;
    int          y;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[18];

  int  cyc, pe_cnt, pe_dbl, hs_lo, hs_bad, vs_lines, vs_bad, de_cnt, de_bad, rgb_bad;
  int  seen, bad, k;
  bit  prev_pe;

  initial begin
    vecs[0]  = '{2'd0, 12'h000, 0,  0, 12'hFFF};
    vecs[1]  = '{2'd0, 12'h000, 1,  3, 12'hFFF};
    vecs[2]  = '{2'd0, 12'h000, 2,  0, 12'hFF0};
    vecs[3]  = '{2'd0, 12'h000, 3,  7, 12'hFF0};
    vecs[4]  = '{2'd0, 12'h000, 5,  1, 12'h0FF};
    vecs[5]  = '{2'd0, 12'h000, 9,  0, 12'hF0F};
    vecs[6]  = '{2'd0, 12'h000, 14, 6, 12'h000};
    vecs[7]  = '{2'd0, 12'h000, 15, 2, 12'h000};
    vecs[8]  = '{2'd1, 12'h000, 4,  1, 12'hFFF};
    vecs[9]  = '{2'd1, 12'h000, 1,  4, 12'hFFF};
    vecs[10] = '{2'd1, 12'h000, 5,  5, 12'h000};
    vecs[11] = '{2'd1, 12'h000, 3,  3, 12'h000};
    vecs[12] = '{2'd2, 12'hA5C, 7,  2, 12'hA5C};
    vecs[13] = '{2'd2, 12'hA5C, 20, 2, 12'h000};
    vecs[14] = '{2'd3, 12'h000, 4,  0, 12'hFFF};
    vecs[15] = '{2'd3, 12'h000, 0,  0, 12'h000};
    vecs[16] = '{2'd3, 12'h000, 4,  4, 12'h000};
    vecs[17] = '{2'd3, 12'h000, 0,  4, 12'hFFF};

    #2 sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Whole-frame timing statistics over two frames.
    wait_fs("timing_start");
    for (int f = 0; f < 2; f++) begin
      cyc = 0; pe_cnt = 0; pe_dbl = 0; hs_lo = 0; hs_bad = 0; vs_lines = 0;
      vs_bad = 0; de_cnt = 0; de_bad = 0; rgb_bad = 0; prev_pe = pix_en;
      do begin
        if (pix_en) begin
          pe_cnt++;
          if (prev_pe) pe_dbl++;
        end
        prev_pe = pix_en;
        if (!pix_en) begin
          if (!hsync) begin
            if (vcount == 4'd0) hs_lo++;
            if (hcount < 5'd18 || hcount > 5'd20) hs_bad++;
          end
          if (!vsync) begin
            if (hcount == 5'd0) vs_lines++;
            if (vcount < 4'd9 || vcount > 4'd10) vs_bad++;
          end
          if (de) begin
            de_cnt++;
            if (hcount >= 5'd16 || vcount >= 4'd8) de_bad++;
          end else if (rgb != 12'h000) begin
            rgb_bad++;
          end
        end
        step();
        cyc++;
      end while (!frame_start && cyc < 2 * FRAME_CYC);
      chk("frame_start_period", cyc, FRAME_CYC);
      chk("pix_en_count", pe_cnt, HT * VT);
      chk("pix_en_back_to_back", pe_dbl, 0);
      chk("hsync_low_pixels", hs_lo, HS);
      chk("hsync_low_outside_18_20", hs_bad, 0);
      chk("vsync_low_lines", vs_lines, VS);
      chk("vsync_low_outside_9_10", vs_bad, 0);
      chk("de_active_pixels", de_cnt, HA * VA);
      chk("de_outside_active", de_bad, 0);
      chk("rgb_nonzero_when_de_low", rgb_bad, 0);
    end

    for (int i = 0; i < 18; i++) begin
      @(negedge sys_clk);
      pat_sel   = vecs[i].sel;
      pat_color = vecs[i].color;
      wait_fs($sformatf("vec%0d", i));
      wait_pix(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rgb_p%0d_x%0d_y%0d", i, vecs[i].sel, vecs[i].x, vecs[i].y),
          32'(rgb), 32'(vecs[i].exp_rgb));
    end

    // Mid-frame selection change must not disturb the frame in flight.
    @(negedge sys_clk);
    pat_sel = 2'd0;
    wait_fs("switch_bars");
    wait_pix(0, 3, "switch_line3");
    @(negedge sys_clk);
    pat_sel   = 2'd2;
    pat_color = 12'hA5C;
    seen = 0; bad = 0; k = 0;
    do begin
      if (!pix_en && de) begin
        seen++;
        if (rgb != ref_rgb(0, 12'h000, int'(hcount), int'(vcount))) bad++;
      end
      step();
      k++;
    end while (!frame_start && k < 2 * FRAME_CYC);
    chk("switch_rest_pixels_seen", seen, (VA - 3) * HA);
    chk("switch_rest_stays_bars", bad, 0);
    chk("switch_next_fs_seen", 32'(frame_start), 32'd1);
    seen = 0; k = 0;
    do begin
      if (!pix_en && de && rgb == 12'hA5C) seen++;
      step();
      k++;
    end while (!frame_start && k < 2 * FRAME_CYC);
    chk("switch_next_frame_a5c_pixels", seen, HA * VA);

    // Randomised selection changes; the reference model checks every cycle.
    for (int c = 0; c < 6 * FRAME_CYC; c++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 99) < 2) begin
        pat_sel   = 2'($urandom_range(0, 3));
        pat_color = 12'($urandom);
      end
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge sys_clk);
    pat_sel   = 2'd2;
    pat_color = 12'h123;
    wait_fs("rst_setup");
    wait_pix(10, 5, "rst_point");
    chk("rst_pre_rgb", 32'(rgb), 32'h123);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_pix_en", 32'(pix_en), 32'd0);
    chk("rst_hcount", 32'(hcount), 32'd0);
    pat_sel = 2'd0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < 20);
    chk("rst_release_fs_delay", k, 2);
    chk("rst_release_bars_rgb", 32'(rgb), 32'hFFF);
    wait_fs("rst_final_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
